// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - controller states and ALU op codes shared by the shared-ALU slice
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOT_A = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_CMP   = 3'b111;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - command and response channels between requesters and the controller
interface alu_share_ctrl_if #(
  parameter int W  = 2,
  parameter int RW = 4,
  parameter int CW = 3
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [1:0]      req_cin;
  logic [2*CW-1:0] req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [RW-1:0]   rsp_result;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/ALU_2bit.sv
// rtl/ALU_2bit.sv - combinational 2-bit signed ALU with 4-bit result
module ALU_2bit
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  input  logic [2:0] ctrl,
  output logic [3:0] result
);
  logic signed [3:0] ax;
  logic signed [3:0] bx;

  assign ax = {{2{a[1]}}, a};
  assign bx = {{2{b[1]}}, b};

  // CMP packs {0, 0, a<b, a==b}; SUB treats cin as an incoming borrow
  always_comb begin
    result = 4'b0000;
    case (ctrl)
      OP_AND:   result = ax & bx;
      OP_OR:    result = ax | bx;
      OP_XOR:   result = ax ^ bx;
      OP_NOT_A: result = ~ax;
      OP_ADD:   result = ax + bx + {3'b000, cin};
      OP_SUB:   result = ax - bx - {3'b000, cin};
      OP_MUL:   result = ax * bx;
      OP_CMP:   result = {2'b00, (ax < bx), (ax == bx)};
      default:  result = 4'b0000;
    endcase
  end
endmodule

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rtl/alu_share_ctrl_rr_arb2.sv - two-way round-robin grant, combinational
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one ALU between two requesters, one command in flight
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W    = 2,
  parameter int RW   = 4,
  parameter int CW   = 3,
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_cin,
  output logic [CW-1:0]    alu_ctrl,
  input  logic [RW-1:0]    alu_result,
  output logic             busy,
  output logic [CNTW-1:0]  op_count0,
  output logic [CNTW-1:0]  op_count1
);
  state_t          state, state_nxt;
  logic [1:0]      grant;
  logic            gid;
  logic            accept;
  logic            rr_ptr;
  logic [W-1:0]    lat_a, lat_b;
  logic            lat_cin;
  logic [CW-1:0]   lat_op;
  logic            id_q;
  logic [RW-1:0]   result_q;

  rr_arb2 u_arb (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign gid            = grant[1];
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // req_ready is gated by rst so nothing is offered while reset is held
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_cin       = 1'b0;
    alu_ctrl      = '0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        bus.req_ready = rst ? 2'b00 : grant;
        accept        = !rst && (grant != 2'b00);
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        alu_a     = lat_a;
        alu_b     = lat_b;
        alu_cin   = lat_cin;
        alu_ctrl  = lat_op;
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_cin   <= 1'b0;
      lat_op    <= '0;
      id_q      <= 1'b0;
      result_q  <= '0;
      op_count0 <= '0;
      op_count1 <= '0;
    end else begin
      if (accept) begin
        rr_ptr  <= ~gid;
        lat_a   <= gid ? bus.req_a[2*W-1:W]   : bus.req_a[W-1:0];
        lat_b   <= gid ? bus.req_b[2*W-1:W]   : bus.req_b[W-1:0];
        lat_cin <= gid ? bus.req_cin[1]       : bus.req_cin[0];
        lat_op  <= gid ? bus.req_op[2*CW-1:CW] : bus.req_op[CW-1:0];
        id_q    <= gid;
      end
      if (state == EXEC) result_q <= alu_result;
      if (state == RESP && bus.rsp_ready) begin
        if (!id_q && op_count0 != {CNTW{1'b1}}) op_count0 <= op_count0 + CNTW'(1);
        if ( id_q && op_count1 != {CNTW{1'b1}}) op_count1 <= op_count1 + CNTW'(1);
      end
    end
  end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester controller that shares one combinational 2-bit signed ALU (`ALU_2bit`) between two command sources. It arbitrates round-robin, drives the ALU operand/control inputs for one cycle, registers the 4-bit result, and returns it with the requester ID over a valid/ready response channel. It sits between the command sources and the single `ALU_2bit` instance in the datapath.

## Interface
- `W`, 2, operand width (signed); must match the ALU.
- `RW`, 4, result width (2*W).
- `CW`, 3, ALU control width.
- `CNTW`, 16, width of per-requester completed-op counters.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  2  command valid, bit i = requester i.
- `req_ready`  out  2  command accepted this cycle when `valid[i]&&ready[i]`.
- `req_a`  in  2*W  operand A; slice [i*W +: W] belongs to requester i.
- `req_b`  in  2*W  operand B, same packing.
- `req_cin`  in  2  carry-in per requester.
- `req_op`  in  2*CW  ALU control per requester.
- `alu_a`, `alu_b`  out  W each  to ALU.
- `alu_cin`  out  1  to ALU.
- `alu_ctrl`  out  CW  to ALU.
- `alu_result`  in  RW  from ALU; combinational from the `alu_*` outputs.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accepted.
- `rsp_id`  out  1  requester that issued the command.
- `rsp_result`  out  RW  registered ALU result.
- `busy`  out  1  high when state is not IDLE.
- `op_count0`, `op_count1`  out  CNTW each  completed responses per requester, saturating.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: the arbiter selects one valid requester. `req_ready` is combinational and one-hot or zero; it is nonzero only in IDLE.
  - Both valid: the requester named by the priority pointer `rr_ptr` wins.
  - One valid: that requester wins.
  - On accept: latch operands, cin, op and ID; set `rr_ptr` to the non-granted requester; go to EXEC.
- EXEC: `alu_*` outputs carry the latched command for exactly this cycle. Capture `alu_result` into `rsp_result` and go to RESP.
- RESP: `rsp_valid` is 1, and `rsp_id`/`rsp_result` hold stable while `rsp_ready` is 0.
  - On `rsp_ready`: increment the counter for `rsp_id` (it holds at 2^CNTW-1) and go to IDLE.
- Outside EXEC, the `alu_*` outputs are driven to 0.
- A requester that drops `req_valid` before being granted loses nothing; no request state is kept.
- Result width: `rsp_result` is the full RW-bit ALU output, unmodified. Signedness is the ALU's concern.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `alu_a/b/cin/ctrl`=0, `busy`=0, both counters 0, `rr_ptr`=0 (requester 0 first).
- Latency: accept at cycle N, EXEC at N+1, `rsp_valid` rises at N+2.
- Throughput: with `rsp_ready` tied high, at most one op per 3 cycles. The next accept can happen in the cycle after the response handshake.
- One command is outstanding at most. `req_ready` stays 0 from EXEC until the cycle after the response handshake.
- `rst` asserted in any state: on the next edge, return to IDLE with all reset values. Any in-flight command and response is discarded, and counters are cleared.
- The `rr_ptr` update happens only on accept. It does not change while idle with no requests.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - the state enum (IDLE/EXEC/RESP);
  - op constants: AND=3'b000, OR=3'b001, XOR=3'b010, NOT_A=3'b011, ADD=3'b100, SUB=3'b101, MUL=3'b110, CMP=3'b111.
- One sub-module, `rr_arb2`: a 2-way round-robin grant from `req_valid` and `rr_ptr`, purely combinational. The FSM, latches and counters live in `alu_share_ctrl`.
- The bench instantiates `alu_share_ctrl` together with the real `ALU_2bit`.

## Test plan
- Reset then idle: hold `rst` for 2 cycles with `req_valid`=2'b11. Required: all outputs 0, `req_ready`=0 during reset; on the first cycle after reset, `req_ready`=2'b01.
- Single ADD: requester 0 sends A=1, B=1, op=ADD, cin=0, accepted at cycle N. Required: `rsp_valid` at N+2 with `rsp_result`=4'b0010, `rsp_id`=0, and `op_count0`=1 after the handshake.
- Signed SUB: requester 1 sends A=-1 (2'b11), B=1, op=SUB. Required: `rsp_result`=4'b1110 (-2), `rsp_id`=1.
- Fairness: both requesters valid continuously with `rsp_ready`=1. Required: grants alternate 0,1,0,1 and `rsp_id` alternates the same way over 4 responses, each 3 cycles apart.
- Backpressure: hold `rsp_ready`=0 for 5 cycles during RESP. Required:
  - `rsp_result`/`rsp_id` stay stable;
  - `req_ready`=0 throughout;
  - exactly one counter increment on release.
- Reset mid-op: assert `rst` in EXEC. Required: the next cycle is IDLE with `rsp_valid`=0, counters 0, and no response ever delivered for the aborted command.
